// File: rtl/uart_rx_if.sv
// UART receiver bus: serial line and pop request into the receiver,
// head-of-FIFO word, flags and status back out.
interface uart_rx_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          rx_in;
    logic                          rd_en;
    logic [DATA_BITS-1:0]          data;
    logic                          valid;
    logic                          parity_err;
    logic                          frame_err;
    logic                          overrun;
    logic                          break_det;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    modport master (
        output rx_in, rd_en,
        input  data, valid, parity_err, frame_err, overrun, break_det, fifo_count
    );

    modport slave (
        input  rx_in, rd_en,
        output data, valid, parity_err, frame_err, overrun, break_det, fifo_count
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, triple-sample majority
// per bit, start-glitch rejection, parity/framing/break detection, and a
// show-ahead FIFO holding {data, parity_err, frame_err} per received word.
//
//  state       | meaning
//  ------------+---------------------------------------------------------
//  ST_IDLE     | line idle, waiting for a 1->0 edge on rx_s
//  ST_START    | validating the start bit (majority 1 = glitch)
//  ST_DATA     | shifting in DATA_BITS bits, LSB first
//  ST_PAR      | sampling the parity bit
//  ST_STOP     | sampling stop bit(s); frame completes at the last H+1 sample
//  ST_BRK      | break seen, waiting for the line to return high
module uart_rx_param #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_p,
    uart_rx_if.slave bus
);
    localparam int TICKS = CLK_FREQ / BAUD_RATE;
    localparam int H     = TICKS / 2;
    localparam int TW    = $clog2(TICKS);
    localparam int BW    = $clog2(DATA_BITS);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int EW    = DATA_BITS + 2;

    localparam logic [TW-1:0] T_S0  = TW'(H - 1);
    localparam logic [TW-1:0] T_S1  = TW'(H);
    localparam logic [TW-1:0] T_S2  = TW'(H + 1);
    localparam logic [TW-1:0] T_END = TW'(TICKS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_BRK} state_t;

    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    state_t               state_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [1:0]           samp_q;
    logic                 perr_q, ferr_q, par_bit_q, stop0_q;

    logic                 maj, stop_last, ferr_now, first_stop_zero, is_break;
    logic                 frame_done, push_req;

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 full, do_pop, do_push;
    logic [EW-1:0]        head;

    // Two-flop synchroniser plus an edge-history flop; all reset high so
    // reset release never looks like a start edge.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx_in;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign maj             = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign stop_last       = (stop_idx_q == 1'(STOP_BITS - 1));
    assign ferr_now        = ferr_q | ~maj;
    assign first_stop_zero = (STOP_BITS == 1) ? ~maj : ~stop0_q;
    assign is_break        = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && first_stop_zero;
    assign frame_done      = (state_q == ST_STOP) && (tick_q == T_S2) && stop_last;
    assign push_req        = frame_done & ~is_break;

    // Receive FSM with bit timer, sampling and per-frame error tracking.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            samp_q     <= 2'b00;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            par_bit_q  <= 1'b0;
            stop0_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tick_q <= '0;
                    if (rx_prev_q && !rx_s_q) begin
                        state_q <= ST_START;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                ST_BRK: begin
                    tick_q <= '0;
                    if (rx_s_q) state_q <= ST_IDLE;
                end
                default: begin
                    tick_q <= (tick_q == T_END) ? '0 : tick_q + TW'(1);
                    if (tick_q == T_S0) samp_q[0] <= rx_s_q;
                    if (tick_q == T_S1) samp_q[1] <= rx_s_q;
                    case (state_q)
                        ST_START: begin
                            if (tick_q == T_S2 && maj) begin
                                state_q <= ST_IDLE;
                            end else if (tick_q == T_END) begin
                                state_q   <= ST_DATA;
                                bit_idx_q <= '0;
                            end
                        end
                        ST_DATA: begin
                            if (tick_q == T_S2) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                            if (tick_q == T_END) begin
                                if (bit_idx_q == B_LAST) begin
                                    state_q    <= (PARITY == 0) ? ST_STOP : ST_PAR;
                                    stop_idx_q <= 1'b0;
                                end else begin
                                    bit_idx_q <= bit_idx_q + BW'(1);
                                end
                            end
                        end
                        ST_PAR: begin
                            if (tick_q == T_S2) begin
                                par_bit_q <= maj;
                                perr_q    <= (PARITY == 1) ? ~((^shift_q) ^ maj) : ((^shift_q) ^ maj);
                            end
                            if (tick_q == T_END) begin
                                state_q    <= ST_STOP;
                                stop_idx_q <= 1'b0;
                            end
                        end
                        default: begin
                            if (tick_q == T_S2) begin
                                ferr_q <= ferr_now;
                                if (!stop_idx_q) stop0_q <= maj;
                            end
                            // Leave right after the last stop sample so an
                            // early next start edge is not missed.
                            if (tick_q == T_S2 && stop_last) begin
                                state_q <= is_break ? ST_BRK : ST_IDLE;
                            end else if (tick_q == T_END) begin
                                stop_idx_q <= 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign do_pop  = bus.rd_en & (count_q != '0);
    assign do_push = push_req & (~full | do_pop);

    // FIFO storage; contents need no reset since outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= {shift_q, perr_q, ferr_now};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    assign head           = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.data       = head[EW-1:2];
    assign bus.parity_err = head[1];
    assign bus.frame_err  = head[0];
    assign bus.valid      = (count_q != '0);
    assign bus.fifo_count = count_q;
    assign bus.overrun    = push_req & full & ~do_pop;
    assign bus.break_det  = frame_done & is_break;
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: an 8N1 receiver and an 8E1 receiver, both at 16 clocks
// per bit, driven with hand-built frames and checked against fixed values.
module tb_uart_rx_param;
    localparam int CLK_FREQ = 1_843_200;
    localparam int BAUD     = 115200;
    localparam int TB       = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic reset_p;
    int   checks = 0;
    int   errors = 0;
    int   brk_a  = 0;
    int   ovr_a  = 0;

    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_a ();
    uart_rx_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_b ();

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut_a (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus_a)
    );

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .PARITY(2)) dut_b (
        .clk     (clk),
        .reset_p (reset_p),
        .bus     (bus_b)
    );

    // Pulse counters for the one-cycle outputs of the 8N1 receiver.
    always begin
        @(negedge clk);
        #1;
        if (bus_a.break_det) brk_a = brk_a + 1;
        if (bus_a.overrun)   ovr_a = ovr_a + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) bus_a.rx_in = v;
        else          bus_b.rx_in = v;
    endtask

    task automatic bit_time(input int sel, input logic v);
        set_rx(sel, v);
        repeat (TB) @(negedge clk);
    endtask

    // One frame: start, 8 data bits LSB first, optional parity, one stop.
    // rd_done pulses rd_en on receiver A in the frame's completion cycle.
    task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop, input bit rd_done);
        bit_time(sel, 1'b0);
        for (int i = 0; i < 8; i++) bit_time(sel, d[i]);
        if (has_par) bit_time(sel, par);
        set_rx(sel, stop);
        if (rd_done) begin
            repeat (TB/2 + 4) @(negedge clk);
            bus_a.rd_en = 1'b1;
            @(negedge clk);
            bus_a.rd_en = 1'b0;
            repeat (TB/2 - 5) @(negedge clk);
        end else begin
            repeat (TB) @(negedge clk);
        end
    endtask

    task automatic pop(input int sel);
        if (sel == 0) bus_a.rd_en = 1'b1;
        else          bus_b.rd_en = 1'b1;
        @(negedge clk);
        bus_a.rd_en = 1'b0;
        bus_b.rd_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int b0;
        int o0;
        reset_p     = 1'b1;
        bus_a.rx_in = 1'b1;
        bus_b.rx_in = 1'b1;
        bus_a.rd_en = 1'b0;
        bus_b.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus_a.valid), 32'h0);
        check("rst_count", 32'(bus_a.fifo_count), 32'h0);
        check("rst_data",  32'(bus_a.data), 32'h0);
        check("rst_flags", {30'h0, bus_a.parity_err, bus_a.frame_err}, 32'h0);
        check("rst_pulses", {30'h0, bus_a.overrun, bus_a.break_det}, 32'h0);
        reset_p = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_valid", 32'(bus_a.valid), 32'h0);

        // Basic 8N1 word
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        check("a5_valid", 32'(bus_a.valid), 32'h1);
        check("a5_data",  32'(bus_a.data), 32'hA5);
        check("a5_flags", {30'h0, bus_a.parity_err, bus_a.frame_err}, 32'h0);
        check("a5_count", 32'(bus_a.fifo_count), 32'h1);
        pop(0);
        check("a5_pop_valid", 32'(bus_a.valid), 32'h0);

        // Even parity: 0x3C has four ones, so parity bit 1 is wrong
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        check("3c_data", 32'(bus_b.data), 32'h3C);
        check("3c_perr", 32'(bus_b.parity_err), 32'h1);
        check("3c_ferr", 32'(bus_b.frame_err), 32'h0);
        pop(1);
        send_frame(1, 8'h3D, 1'b1, 1'b1, 1'b1, 1'b0);
        check("3d_data", 32'(bus_b.data), 32'h3D);
        check("3d_perr", 32'(bus_b.parity_err), 32'h0);
        pop(1);
        check("b_empty", 32'(bus_b.fifo_count), 32'h0);

        // Framing error, then recovery
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        check("81_data", 32'(bus_a.data), 32'h81);
        check("81_ferr", 32'(bus_a.frame_err), 32'h1);
        bit_time(0, 1'b1);
        pop(0);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        check("55_data", 32'(bus_a.data), 32'h55);
        check("55_ferr", 32'(bus_a.frame_err), 32'h0);
        pop(0);

        // Start glitch of three clocks
        set_rx(0, 1'b0);
        repeat (3) @(negedge clk);
        set_rx(0, 1'b1);
        repeat (3 * TB) @(negedge clk);
        check("glitch_valid", 32'(bus_a.valid), 32'h0);
        check("glitch_count", 32'(bus_a.fifo_count), 32'h0);
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
        check("12_data", 32'(bus_a.data), 32'h12);
        pop(0);

        // Break: 20 bit times low
        b0 = brk_a;
        set_rx(0, 1'b0);
        repeat (20 * TB) @(negedge clk);
        check("brk_pulses", 32'(brk_a - b0), 32'h1);
        check("brk_valid", 32'(bus_a.valid), 32'h0);
        bit_time(0, 1'b1);
        send_frame(0, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b0);
        check("7e_data", 32'(bus_a.data), 32'h7E);
        check("7e_count", 32'(bus_a.fifo_count), 32'h1);
        check("brk_once", 32'(brk_a - b0), 32'h1);
        pop(0);

        // Overflow with no reads
        o0 = ovr_a;
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
        check("ovf_pulses", 32'(ovr_a - o0), 32'h1);
        check("ovf_count", 32'(bus_a.fifo_count), 32'h4);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_read", 32'(bus_a.data), 32'(i));
            pop(0);
        end
        check("ovf_empty", 32'(bus_a.valid), 32'h0);

        // Full FIFO with a pop in the completion cycle
        o0 = ovr_a;
        for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1);
        check("rdw_no_ovr", 32'(ovr_a - o0), 32'h0);
        check("rdw_count", 32'(bus_a.fifo_count), 32'h4);
        for (int i = 2; i <= 5; i++) begin
            check("rdw_read", 32'(bus_a.data), 32'(i));
            pop(0);
        end
        check("rdw_empty", 32'(bus_a.fifo_count), 32'h0);

        // Pop while empty is ignored
        pop(0);
        check("underflow_count", 32'(bus_a.fifo_count), 32'h0);
        check("underflow_valid", 32'(bus_a.valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver that replaces the fixed 8N1 receivers.
- Configurable baud, data width, parity and stop bits.
- Triple-sample majority vote per bit, start-glitch rejection, and detection of framing error, parity error and break.
- Received words, with their error flags, are buffered in a small show-ahead FIFO. This lets motor and LCD command parsers drain bytes without losing back-to-back frames.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz.
- BAUD_RATE, 115200, line rate in bps. TICKS = CLK_FREQ/BAUD_RATE, integer-truncated; TICKS must be >= 8.
- DATA_BITS, 8, data bits per frame, 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- FIFO_DEPTH, 4, number of entries, power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- reset_p  in  1  asynchronous, active-high reset.
- rx_in  in  1  serial line, idle high, asynchronous to clk.
- rd_en  in  1  pop the head entry; honoured only when valid=1.
- data  out  DATA_BITS  head entry data, LSB = first received bit.
- valid  out  1  FIFO not empty.
- parity_err  out  1  head entry had a parity mismatch (always 0 when PARITY=0).
- frame_err  out  1  head entry had at least one stop-bit sample of 0.
- overrun  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full.
- break_det  out  1  one-cycle pulse: break frame detected.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async, reset_p=1):
  - All outputs 0; FIFO empty; FSM in IDLE.
  - Both rx synchroniser flops reset to 1, so no false start is detected on reset release.
- Synchroniser: 2-flop on rx_in, giving rx_s. All decisions use rx_s.
- Bit timer:
  - tick_cnt counts 0..TICKS-1 within each bit.
  - Samples are taken at tick_cnt = H-1, H and H+1, where H = TICKS/2.
  - Bit value = majority of the three samples, resolved at tick_cnt = H+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: a 1->0 transition on rx_s goes to START with tick_cnt = 0.
  - START:
    - Majority 1 = glitch: return to IDLE and push nothing.
    - Majority 0: at tick_cnt = TICKS-1 go to DATA with bit index 0.
  - DATA:
    - Shift in DATA_BITS bits, LSB first.
    - After the last bit go to PARITY, or to STOP if PARITY = 0.
  - PARITY:
    - Odd mode: perr = 1 when XOR(data, parity bit) = 0.
    - Even mode: perr = 1 when XOR(data, parity bit) = 1.
  - STOP:
    - Sample STOP_BITS stop bits; ferr = 1 if any stop majority is 0.
    - Frame completes at the H+1 sample of the final stop bit.
    - The FSM returns to IDLE in the next cycle and does not wait for the end of the stop bit, so a start edge half a bit later is caught.
  - Break: at frame completion, if all data bits, the parity bit (if present) and the first stop bit are 0:
    - Assert break_det for one cycle.
    - Push nothing.
    - Go to BREAK_WAIT.
  - BREAK_WAIT: stay until rx_s = 1, then go to IDLE.
- Push at frame completion (non-break):
  - Write {data, perr, ferr} in the completion cycle.
  - If the FIFO is full and rd_en=0: drop the frame and pulse overrun in the same cycle.
  - If the FIFO is full and rd_en=1 in the same cycle: pop and push both occur, count stays FIFO_DEPTH, no overrun.
- FIFO (show-ahead):
  - data, parity_err and frame_err always reflect the head entry; they are 0 when empty.
  - Pop takes effect on the clock edge where rd_en=1 and valid=1; the next entry is visible the following cycle.
  - rd_en while empty is ignored: no underflow, count stays 0.
  - Read and write pointers wrap modulo FIFO_DEPTH; the count distinguishes full from empty.
- Latency: a frame's fields and valid appear on the cycle after the completion cycle.
- Flags are per entry, not sticky; overrun and break_det are never held.

Test Plan:
- Defaults (115200, 8N1). Send 0xA5 with an ideal stop bit:
  - Required: valid=1, data=0xA5, parity_err=0, frame_err=0, fifo_count=1.
  - Then rd_en for 1 cycle gives valid=0 next cycle.
- PARITY=2, DATA_BITS=8:
  - Send 0x3C with parity bit 1 (wrong): data=0x3C, parity_err=1.
  - Then send 0x3D with parity bit 1 (correct): parity_err=0 on that entry.
- 8N1, 0x81 with stop bit driven 0:
  - Required: data=0x81, frame_err=1.
  - Line returned high one bit later, then 0x55 sent: data=0x55, frame_err=0.
- Glitch: 3-clock low pulse on rx_in.
  - Required: no push, valid stays 0.
  - A subsequent 0x12 is received correctly.
- Break: hold rx_in low for 20 bit times.
  - Required: exactly one break_det pulse, no FIFO entry.
  - After rx_in goes high, 0x7E is received normally.
- Overflow: FIFO_DEPTH=4, 5 back-to-back frames 0x01..0x05 with no reads.
  - Required: overrun pulses once on the 5th frame; fifo_count=4; reads return 0x01..0x04.
  - Repeat with rd_en asserted in the 5th completion cycle: no overrun, 0x05 is retained.
